// File: rtl/cpu4004_pkg.sv
// Shared 4004 core definitions: machine-cycle phases, data bus buffer path codes,
// internal bus source selects and execute-class codes.
package cpu4004_pkg;

    typedef enum logic [2:0] {
        PH_A1 = 3'd0,
        PH_A2 = 3'd1,
        PH_A3 = 3'd2,
        PH_M1 = 3'd3,
        PH_M2 = 3'd4,
        PH_X1 = 3'd5,
        PH_X2 = 3'd6,
        PH_X3 = 3'd7
    } phase_e;

    // Data bus buffer direction; the buffer block imports these codes.
    localparam logic [1:0] PATH_OUT  = 2'b00;
    localparam logic [1:0] PATH_IN   = 2'b01;
    localparam logic [1:0] PATH_IDLE = 2'b10;

    localparam logic [1:0] SEL_PC      = 2'b00;
    localparam logic [1:0] SEL_ACC     = 2'b01;
    localparam logic [1:0] SEL_PAIR_HI = 2'b10;
    localparam logic [1:0] SEL_PAIR_LO = 2'b11;

    typedef enum logic [1:0] {
        XC_NONE  = 2'd0,
        XC_READ  = 2'd1,
        XC_WRITE = 2'd2,
        XC_SRC   = 2'd3
    } xclass_e;

    function automatic xclass_e classify(input logic src_instr, input logic io_write,
                                         input logic io_read);
        xclass_e cls;
        if (src_instr) begin
            cls = XC_SRC;
        end else if (io_write) begin
            cls = XC_WRITE;
        end else if (io_read) begin
            cls = XC_READ;
        end else begin
            cls = XC_NONE;
        end
        return cls;
    endfunction

endpackage

// File: rtl/machine_cycle_timing.sv
// Eight-phase 4004 machine-cycle sequencer: phase counter plus Moore decode of
// bus buffer controls, selects, strobes, SYNC and CM lines.
module machine_cycle_timing
    import cpu4004_pkg::*;
(
    input  logic       clk_2,
    input  logic       reset,
    input  logic       two_word,
    input  logic       io_read,
    input  logic       io_write,
    input  logic       src_instr,
    output logic       data_bus_buffer_enable,
    output logic [1:0] data_bus_buffer_path,
    output logic [1:0] out_src_sel,
    output logic [1:0] addr_nibble_sel,
    output logic       opr_load,
    output logic       opa_load,
    output logic       operand_hi_load,
    output logic       operand_lo_load,
    output logic       io_load,
    output logic       sync,
    output logic       cm_rom,
    output logic       cm_ram,
    output logic [2:0] phase
);

    phase_e  phase_q, phase_d;
    xclass_e xclass_q, xclass_d;
    logic    second_word_q, second_word_d;
    logic    pending_two_q, pending_two_d;

    // State register with synchronous reset.
    always_ff @(posedge clk_2) begin
        if (reset) begin
            phase_q       <= PH_A1;
            xclass_q      <= XC_NONE;
            second_word_q <= 1'b0;
            pending_two_q <= 1'b0;
        end else begin
            phase_q       <= phase_d;
            xclass_q      <= xclass_d;
            second_word_q <= second_word_d;
            pending_two_q <= pending_two_d;
        end
    end

    // Next state: free-running phase, class capture leaving M2, word tracking leaving X3.
    always_comb begin
        phase_d       = phase_e'(phase_q + 3'd1);
        xclass_d      = xclass_q;
        second_word_d = second_word_q;
        pending_two_d = pending_two_q;
        case (phase_q)
            PH_M2: begin
                if (second_word_q) begin
                    // Operand word carries no execute activity of its own.
                    xclass_d = XC_NONE;
                end else begin
                    xclass_d      = classify(src_instr, io_write, io_read);
                    pending_two_d = two_word;
                end
            end
            PH_X3: begin
                second_word_d = pending_two_q & ~second_word_q;
                pending_two_d = 1'b0;
                xclass_d      = XC_NONE;
            end
            default: begin
                xclass_d = xclass_q;
            end
        endcase
    end

    // Output decode from registered state, forced inactive while reset is high.
    always_comb begin
        data_bus_buffer_enable = 1'b0;
        data_bus_buffer_path   = PATH_IDLE;
        out_src_sel            = SEL_PC;
        addr_nibble_sel        = 2'd0;
        opr_load               = 1'b0;
        opa_load               = 1'b0;
        operand_hi_load        = 1'b0;
        operand_lo_load        = 1'b0;
        io_load                = 1'b0;
        sync                   = 1'b0;
        cm_rom                 = 1'b0;
        cm_ram                 = 1'b0;
        phase                  = 3'd0;
        if (reset) begin
            phase = 3'd0;
        end else begin
            phase = phase_q;
            case (phase_q)
                PH_A1, PH_A2, PH_A3: begin
                    data_bus_buffer_enable = 1'b1;
                    data_bus_buffer_path   = PATH_OUT;
                    addr_nibble_sel        = phase_q[1:0];
                    cm_rom                 = (phase_q == PH_A3);
                end
                PH_M1: begin
                    data_bus_buffer_enable = 1'b1;
                    data_bus_buffer_path   = PATH_IN;
                    opr_load               = ~second_word_q;
                    operand_hi_load        = second_word_q;
                end
                PH_M2: begin
                    data_bus_buffer_enable = 1'b1;
                    data_bus_buffer_path   = PATH_IN;
                    opa_load               = ~second_word_q;
                    operand_lo_load        = second_word_q;
                end
                PH_X2: begin
                    case (xclass_q)
                        XC_SRC: begin
                            data_bus_buffer_enable = 1'b1;
                            data_bus_buffer_path   = PATH_OUT;
                            out_src_sel            = SEL_PAIR_HI;
                            cm_ram                 = 1'b1;
                        end
                        XC_WRITE: begin
                            data_bus_buffer_enable = 1'b1;
                            data_bus_buffer_path   = PATH_OUT;
                            out_src_sel            = SEL_ACC;
                        end
                        XC_READ: begin
                            data_bus_buffer_enable = 1'b1;
                            data_bus_buffer_path   = PATH_IN;
                            io_load                = 1'b1;
                        end
                        default: begin
                            data_bus_buffer_enable = 1'b0;
                        end
                    endcase
                end
                PH_X3: begin
                    sync = 1'b1;
                    if (xclass_q == XC_SRC) begin
                        data_bus_buffer_enable = 1'b1;
                        data_bus_buffer_path   = PATH_OUT;
                        out_src_sel            = SEL_PAIR_LO;
                    end else begin
                        data_bus_buffer_enable = 1'b0;
                    end
                end
                default: begin
                    data_bus_buffer_enable = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_machine_cycle_timing.sv
// Scoreboard bench for machine_cycle_timing: a per-instruction reference model
// queues the expected output word for each cycle; a monitor compares mid-cycle.
module tb_machine_cycle_timing;

    logic       clk_2 = 1'b0;
    logic       reset = 1'b1;
    logic       two_word = 1'b0, io_read = 1'b0, io_write = 1'b0, src_instr = 1'b0;
    logic       data_bus_buffer_enable;
    logic [1:0] data_bus_buffer_path, out_src_sel, addr_nibble_sel;
    logic       opr_load, opa_load, operand_hi_load, operand_lo_load, io_load;
    logic       sync, cm_rom, cm_ram;
    logic [2:0] phase;

    machine_cycle_timing dut (
        .clk_2(clk_2), .reset(reset), .two_word(two_word), .io_read(io_read),
        .io_write(io_write), .src_instr(src_instr),
        .data_bus_buffer_enable(data_bus_buffer_enable),
        .data_bus_buffer_path(data_bus_buffer_path), .out_src_sel(out_src_sel),
        .addr_nibble_sel(addr_nibble_sel), .opr_load(opr_load), .opa_load(opa_load),
        .operand_hi_load(operand_hi_load), .operand_lo_load(operand_lo_load),
        .io_load(io_load), .sync(sync), .cm_rom(cm_rom), .cm_ram(cm_ram), .phase(phase)
    );

    always #5 clk_2 = ~clk_2;

    // Reference model: position within the instruction, operand-word flag,
    // pending two-word flag and execute class (0 none, 1 read, 2 write, 3 src).
    int m_pos = 0;
    bit m_sec = 0, m_pend = 0;
    int m_cls = 0;
    int cyc = 0;
    int errors = 0, checks = 0;
    logic [17:0] exp_q[$];

    // {en, path, src_sel, addr_sel, opr, opa, ohi, olo, io_load, sync, cm_rom, cm_ram, phase}
    function automatic logic [17:0] expect_out(int pos, bit sec, int cls, bit rst);
        logic en = 0; logic [1:0] path = 2'b10, ssel = 2'b00, asel = 2'b00;
        logic opr = 0, opa = 0, ohi = 0, olo = 0, iol = 0, syn = 0, crom = 0, cram = 0;
        logic [2:0] ph = 3'd0;
        if (!rst) begin
            ph = 3'(pos);
            if (pos <= 2) begin
                en = 1; path = 2'b00; asel = 2'(pos); crom = (pos == 2);
            end else if (pos == 3 || pos == 4) begin
                en = 1; path = 2'b01;
                opr = (pos == 3) && !sec; ohi = (pos == 3) && sec;
                opa = (pos == 4) && !sec; olo = (pos == 4) && sec;
            end else if (pos == 6) begin
                if (cls == 3) begin en = 1; path = 2'b00; ssel = 2'b10; cram = 1; end
                else if (cls == 2) begin en = 1; path = 2'b00; ssel = 2'b01; end
                else if (cls == 1) begin en = 1; path = 2'b01; iol = 1; end
            end else if (pos == 7) begin
                syn = 1;
                if (cls == 3) begin en = 1; path = 2'b00; ssel = 2'b11; end
            end
        end
        return {en, path, ssel, asel, opr, opa, ohi, olo, iol, syn, crom, cram, ph};
    endfunction

    // Advance the model by one clock using the inputs the DUT samples at that edge,
    // then drive the next cycle's inputs and queue that cycle's expected outputs.
    task automatic step(input bit r, input bit tw, input bit rd, input bit wr, input bit sr);
        @(posedge clk_2);
        if (reset) begin
            m_pos = 0; m_sec = 0; m_pend = 0; m_cls = 0;
        end else begin
            if (m_pos == 4) begin
                if (m_sec) m_cls = 0;
                else begin
                    m_cls = src_instr ? 3 : io_write ? 2 : io_read ? 1 : 0;
                    m_pend = two_word;
                end
            end
            if (m_pos == 7) begin
                m_sec = m_pend && !m_sec;
                m_pend = 0; m_cls = 0;
            end
            m_pos = (m_pos + 1) % 8;
        end
        #1;
        reset = r; two_word = tw; io_read = rd; io_write = wr; src_instr = sr;
        exp_q.push_back(expect_out(m_pos, m_sec, m_cls, r));
    endtask

    // One full instruction from A1 with the class inputs presented during M2 only.
    task automatic instr(input bit tw, input bit rd, input bit wr, input bit sr);
        for (int i = 0; i < 8; i++) begin
            if (i == 4) step(0, tw, rd, wr, sr);
            else step(0, 0, 0, 0, 0);
        end
    endtask

    // Monitor: compare the queued expectation against the DUT mid-cycle.
    always @(negedge clk_2) begin
        logic [17:0] got, want;
        if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            got = {data_bus_buffer_enable, data_bus_buffer_path, out_src_sel, addr_nibble_sel,
                   opr_load, opa_load, operand_hi_load, operand_lo_load, io_load,
                   sync, cm_rom, cm_ram, phase};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL outputs cycle %0d: got %b want %b (en path src addr opr opa ohi olo io sync rom ram phase)",
                         cyc, got, want);
            end
            cyc++;
        end
    end

    initial begin
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) step(0, 0, 0, 0, 0);
        instr(0, 0, 1, 0);          // write
        instr(0, 0, 0, 0);
        instr(0, 1, 0, 1);          // src beats read
        instr(1, 0, 0, 0);          // two-word
        instr(1, 0, 0, 0);          // operand word: two_word ignored
        instr(0, 0, 0, 0);
        instr(1, 0, 0, 0);
        instr(0, 1, 0, 0);          // read during operand word: ignored
        for (int i = 0; i < 6; i++) step(0, 0, (i == 4), 0, 0);
        step(1, 0, 0, 0, 0);        // reset at X2 of a read instruction
        instr(0, 0, 0, 0);
        for (int i = 0; i < 800; i++)
            step(($urandom % 50) == 0, $urandom % 2, $urandom % 2, $urandom % 2, $urandom % 3 == 0);
        step(0, 0, 0, 0, 0);
        @(negedge clk_2);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
